// File: rtl/mult_pkg.sv
// Shared types and helpers for the parametrised sequential multiplier.
//   state_e      : control FSM states
//   count_width  : width of an iteration counter able to hold the value WIDTH
//   twos_mag     : magnitude of a 64-bit two's-complement value; the result is
//                  correct as an unsigned number even for the most negative input
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

  // Operands are sign- or zero-extended to 64 bits by the caller, so a single
  // function serves every WIDTH.
  function automatic logic [63:0] twos_mag(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the sequential multiplier.
//   clk, reset : clock and asynchronous active-low reset
//   clear      : zero the count (operand accept)
//   inc        : count one processed bit
//   count      : bits processed so far
//   last       : the next increment brings the count to WIDTH
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            inc,
  output logic [count_width(WIDTH)-1:0]   count,
  output logic                            last
);

  localparam int CW = count_width(WIDTH);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
//   clk, reset          : clock and asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   signed_mode         : operands are two's complement, sampled on accept
//   multiplicand        : operand A
//   multiplier          : operand B
//   out_valid/out_ready : product handshake (out_valid only in DONE)
//   product             : 2*WIDTH-bit result, held until the next operation ends
//   busy                : operation in progress or result waiting
//   iter_count          : bits processed for the current or last operation
// Signed operation multiplies magnitudes and negates the result at the end,
// so the datapath itself is purely unsigned.
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            signed_mode,
  input  logic [WIDTH-1:0]                multiplicand,
  input  logic [WIDTH-1:0]                multiplier,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*WIDTH-1:0]              product,
  output logic                            busy,
  output logic [count_width(WIDTH)-1:0]   iter_count
);

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               accept;
  logic               cnt_last;
  logic               run_exit;
  logic [63:0]        a_ext, b_ext;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_shift;

  assign accept = in_valid && in_ready;

  mult_iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .inc   (state_q == RUN),
    .count (iter_count),
    .last  (cnt_last)
  );

  // Operand magnitudes; raw values pass through in unsigned mode.
  always_comb begin
    a_ext = signed_mode ? 64'($signed(multiplicand)) : 64'(multiplicand);
    b_ext = signed_mode ? 64'($signed(multiplier))   : 64'(multiplier);
    mag_a = WIDTH'(twos_mag(a_ext));
    mag_b = WIDTH'(twos_mag(b_ext));
  end

  // Current bit: conditional add, then decide whether this is the final bit.
  always_comb begin
    acc_sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_shift = mplier_q >> 1;
    run_exit     = cnt_last || (EARLY_TERM && (mplier_shift == '0));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (run_exit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
  end

  // Datapath next values
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (accept) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      neg_d    = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    end else if (state_q == RUN) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_shift;
      // Sign fix-up uses the post-add value so the result lands on the exit edge.
      if (run_exit) begin
        product_d = neg_q ? -acc_sum : acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
module tb_seq_mult_param;

  localparam int W  = 16;
  localparam int CW = $clog2(W) + 1;

  logic clk = 1'b0;
  logic reset, in_valid, signed_mode, out_ready, sel;
  logic [W-1:0] a, b;

  logic in_valid0, in_valid1;
  logic in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [2*W-1:0] product0, product1;
  logic [CW-1:0]  iter0, iter1;

  // sel picks which instance is driven and observed: 0 = EARLY_TERM 0, 1 = EARLY_TERM 1
  logic in_ready, out_valid, busy;
  logic [2*W-1:0] product;
  logic [CW-1:0]  iter_count;

  int checks = 0;
  int errors = 0;

  assign in_valid0  = in_valid & ~sel;
  assign in_valid1  = in_valid & sel;
  assign in_ready   = sel ? in_ready1  : in_ready0;
  assign out_valid  = sel ? out_valid1 : out_valid0;
  assign busy       = sel ? busy1      : busy0;
  assign product    = sel ? product1   : product0;
  assign iter_count = sel ? iter1      : iter0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(W), .EARLY_TERM(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .signed_mode(signed_mode), .multiplicand(a), .multiplier(b),
    .out_valid(out_valid0), .out_ready(out_ready), .product(product0),
    .busy(busy0), .iter_count(iter0)
  );

  seq_mult_param #(.WIDTH(W), .EARLY_TERM(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .signed_mode(signed_mode), .multiplicand(a), .multiplier(b),
    .out_valid(out_valid1), .out_ready(out_ready), .product(product1),
    .busy(busy1), .iter_count(iter1)
  );

  // Present one operand pair, scramble the operand inputs after the accept
  // edge, and count negedges until out_valid is seen (lat = -1 on timeout).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sm, output int lat);
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~av; b = ~bv; signed_mode = ~sm;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d got %b want 1", s, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d got %b want 0", s, out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got %b want 0", s, busy); end
      checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product dut%0d got %h want 00000000", s, product); end
      checks++; if (iter_count !== 5'd0) begin errors++; $display("FAIL reset_iter dut%0d got %0d want 0", s, iter_count); end
    end
    $display("reset state checked on both instances");
  endtask

  // Directed operand table for the EARLY_TERM=0 instance: latency always 17.
  task automatic test_full_iter();
    logic [W-1:0]   ta [6] = '{16'h0003, 16'hFFFF, 16'hFFFF, 16'hFFFD, 16'h8000, 16'h8000};
    logic [W-1:0]   tb [6] = '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h0007, 16'h8000, 16'h0001};
    logic           ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2*W-1:0] tp [6] = '{32'h0000000F, 32'hFFFE0001, 32'h00000001,
                               32'hFFFFFFEB, 32'h40000000, 32'hFFFF8000};
    int lat;
    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], ts[i], lat);
      $display("et0 %h*%h signed=%b -> product=%h lat=%0d iter=%0d", ta[i], tb[i], ts[i], product, lat, iter_count);
      checks++; if (product !== tp[i]) begin errors++; $display("FAIL et0_product[%0d] got %h want %h", i, product, tp[i]); end
      checks++; if (lat != 17) begin errors++; $display("FAIL et0_latency[%0d] got %0d want 17", i, lat); end
      checks++; if (iter_count !== 5'd16) begin errors++; $display("FAIL et0_iter[%0d] got %0d want 16", i, iter_count); end
    end
  endtask

  task automatic test_early_term();
    logic [W-1:0]   ta [4] = '{16'h1234, 16'hABCD, 16'h0003, 16'hFFFD};
    logic [W-1:0]   tb [4] = '{16'h0001, 16'h0000, 16'h8000, 16'h0007};
    logic           ts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2*W-1:0] tp [4] = '{32'h00001234, 32'h00000000, 32'h00018000, 32'hFFFFFFEB};
    int             tn [4] = '{1, 1, 16, 3};
    int lat;
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], ts[i], lat);
      $display("et1 %h*%h signed=%b -> product=%h lat=%0d iter=%0d", ta[i], tb[i], ts[i], product, lat, iter_count);
      checks++; if (product !== tp[i]) begin errors++; $display("FAIL et1_product[%0d] got %h want %h", i, product, tp[i]); end
      checks++; if (lat != tn[i] + 1) begin errors++; $display("FAIL et1_latency[%0d] got %0d want %0d", i, lat, tn[i] + 1); end
      checks++; if (iter_count !== CW'(tn[i])) begin errors++; $display("FAIL et1_iter[%0d] got %0d want %0d", i, iter_count, tn[i]); end
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    sel = 1'b0;
    out_ready = 1'b0;
    run_op(16'd100, 16'd200, 1'b0, lat);
    checks++; if (lat != 17) begin errors++; $display("FAIL bp_latency got %0d want 17", lat); end
    // Keep offering operands while the result is stalled; they must be ignored.
    in_valid = 1'b1; a = 16'h0005; b = 16'h0007; signed_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (product !== 32'h00004E20) begin errors++; $display("FAIL bp_product[%0d] got %h want 00004e20", i, product); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    $display("bp release: out_valid=%b in_ready=%b product=%h", out_valid, in_ready, product);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    checks++; if (product !== 32'h00004E20) begin errors++; $display("FAIL bp_release_product got %h want 00004e20", product); end
    run_op(16'd9, 16'd11, 1'b0, lat);
    $display("bp next op 9*11 -> product=%h lat=%0d", product, lat);
    checks++; if (product !== 32'h00000063) begin errors++; $display("FAIL bp_next_product got %h want 00000063", product); end
    checks++; if (lat != 17) begin errors++; $display("FAIL bp_next_latency got %0d want 17", lat); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    sel = 1'b0;
    @(negedge clk);
    a = 16'd12; b = 16'd12; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (iter_count !== 5'd7) begin errors++; $display("FAIL midrun_iter got %0d want 7", iter_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
    reset = 1'b0;
    #1;
    $display("mid-run reset: out_valid=%b product=%h in_ready=%b iter=%0d", out_valid, product, in_ready, iter_count);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_rst_out_valid got %b want 0", out_valid); end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL midrun_rst_product got %h want 00000000", product); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_rst_in_ready got %b want 1", in_ready); end
    checks++; if (iter_count !== 5'd0) begin errors++; $display("FAIL midrun_rst_iter got %0d want 0", iter_count); end
    @(negedge clk);
    reset = 1'b1;
    run_op(16'd12, 16'd12, 1'b0, lat);
    $display("after reset 12*12 -> product=%h lat=%0d", product, lat);
    checks++; if (product !== 32'h00000090) begin errors++; $display("FAIL midrun_next_product got %h want 00000090", product); end
    checks++; if (lat != 17) begin errors++; $display("FAIL midrun_next_latency got %0d want 17", lat); end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_full_iter();
    test_early_term();
    test_back_pressure();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
